// File: rtl/fg_trapezoid_gen_if.sv
// Bundle between the function-generator register file (master) and the
// trapezoid generator (slave), including the sample-path outputs.
interface fg_trapezoid_gen_if #(
    parameter int COUNTER_BITWIDTH  = 16,
    parameter int WAVEFORM_BITWIDTH = 12,
    parameter int BURST_BITWIDTH    = 8
);
    logic                              clk_en_i;
    logic                              enable_i;
    logic                              start_i;
    logic [1:0]                        mode_i;
    logic [BURST_BITWIDTH-1:0]         burst_len_i;
    logic [COUNTER_BITWIDTH-1:0]       period_i;
    logic [COUNTER_BITWIDTH-1:0]       on_time_i;
    logic [WAVEFORM_BITWIDTH-1:0]      k_rise_i;
    logic [WAVEFORM_BITWIDTH-1:0]      k_fall_i;
    logic [WAVEFORM_BITWIDTH-1:0]      amplitude_i;
    logic                              invert_i;
    logic signed [WAVEFORM_BITWIDTH:0] out_o;
    logic                              busy_o;
    logic                              period_start_o;
    logic [1:0]                        state_o;

    modport master (
        output clk_en_i, enable_i, start_i, mode_i, burst_len_i, period_i,
               on_time_i, k_rise_i, k_fall_i, amplitude_i, invert_i,
        input  out_o, busy_o, period_start_o, state_o
    );

    modport slave (
        input  clk_en_i, enable_i, start_i, mode_i, burst_len_i, period_i,
               on_time_i, k_rise_i, k_fall_i, amplitude_i, invert_i,
        output out_o, busy_o, period_start_o, state_o
    );
endinterface

// File: rtl/fg_trapezoid_gen.sv
// Single-channel trapezoid/pulse generator with period counter, shadowed
// slope/timing settings and continuous, one-shot and burst operation.
module fg_trapezoid_gen #(
    parameter int COUNTER_BITWIDTH  = 16,
    parameter int WAVEFORM_BITWIDTH = 12,
    parameter int BURST_BITWIDTH    = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    fg_trapezoid_gen_if.slave  bus
);
    localparam int CW = COUNTER_BITWIDTH;
    localparam int WW = WAVEFORM_BITWIDTH;
    localparam int BW = BURST_BITWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     val_q, val_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              busy_q, busy_d;
    logic              restart;
    logic [CW-1:0]     period_q, on_time_q;
    logic [WW-1:0]     k_rise_q, k_fall_q, amp_q;
    logic signed [WW:0] out_q, out_d;
    logic [WW:0]       val_ext;
    logic              period_start_q;

    logic              continuous;
    logic [CW-1:0]     period_eff;
    logic              short_period;
    logic [BW-1:0]     burst_len_eff;
    logic [WW:0]       rise_sum;
    logic              fall_done;
    logic [WW-1:0]     fall_val;

    // At cnt==0 the shadows are being reloaded, so the live period decides the wrap.
    assign continuous    = (bus.mode_i == 2'd0) || (bus.mode_i == 2'd3);
    assign period_eff    = (cnt_q == '0) ? bus.period_i : period_q;
    assign short_period  = period_eff < CW'(2);
    assign burst_len_eff = (bus.burst_len_i == '0) ? BW'(1) : bus.burst_len_i;
    assign rise_sum      = {1'b0, val_q} + {1'b0, k_rise_q};
    assign fall_done     = (val_q <= k_fall_q) || (k_fall_q == '0);
    assign fall_val      = val_q - k_fall_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        busy_d  = busy_q;
        burst_d = burst_q;
        restart = 1'b0;
        if (!bus.enable_i || short_period) begin
            state_d = IDLE;
            cnt_d   = '0;
            val_d   = '0;
            busy_d  = 1'b0;
            burst_d = '0;
        end else if (!continuous && !busy_q) begin
            // A start tick only arms the generator; the first period begins on the next tick.
            state_d = IDLE;
            cnt_d   = '0;
            val_d   = '0;
            if (bus.start_i) begin
                busy_d  = 1'b1;
                burst_d = (bus.mode_i == 2'd1) ? BW'(1) : burst_len_eff;
            end
        end else if (!continuous && (cnt_q == '0) && (burst_q == '0)) begin
            cnt_d = '0;
            case (state_q)
                RISE, ON: state_d = FALL;
                FALL: begin
                    if (fall_done) begin
                        val_d   = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        val_d = fall_val;
                    end
                end
                default: begin
                    val_d  = '0;
                    busy_d = 1'b0;
                end
            endcase
        end else begin
            busy_d = 1'b1;
            cnt_d  = (cnt_q == period_eff - CW'(1)) ? '0 : cnt_q + CW'(1);
            if (cnt_q == '0) begin
                restart = 1'b1;
                state_d = RISE;
                if (!continuous) begin
                    burst_d = burst_q - BW'(1);
                end
            end else begin
                case (state_q)
                    RISE: begin
                        if ((rise_sum >= {1'b0, amp_q}) || (k_rise_q == '0)) begin
                            val_d   = amp_q;
                            state_d = ON;
                        end else begin
                            val_d = rise_sum[WW-1:0];
                        end
                        if (cnt_q == on_time_q) begin
                            state_d = FALL;
                        end
                    end
                    ON: begin
                        val_d = amp_q;
                        if (cnt_q == on_time_q) begin
                            state_d = FALL;
                        end
                    end
                    FALL: begin
                        if (fall_done) begin
                            val_d   = '0;
                            state_d = IDLE;
                        end else begin
                            val_d = fall_val;
                        end
                    end
                    default: val_d = '0;
                endcase
            end
        end
    end

    always_comb begin
        val_ext = {1'b0, val_d};
        out_d   = bus.invert_i ? -val_ext : val_ext;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            val_q          <= '0;
            burst_q        <= '0;
            busy_q         <= 1'b0;
            period_q       <= '0;
            on_time_q      <= '0;
            k_rise_q       <= '0;
            k_fall_q       <= '0;
            amp_q          <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= bus.clk_en_i & restart;
            if (bus.clk_en_i) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                val_q   <= val_d;
                burst_q <= burst_d;
                busy_q  <= busy_d;
                out_q   <= out_d;
                if (restart) begin
                    period_q  <= bus.period_i;
                    on_time_q <= bus.on_time_i;
                    k_rise_q  <= bus.k_rise_i;
                    k_fall_q  <= bus.k_fall_i;
                    amp_q     <= bus.amplitude_i;
                end
            end
        end
    end

    assign bus.out_o          = out_q;
    assign bus.busy_o         = busy_q;
    assign bus.period_start_o = period_start_q;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_fg_trapezoid_gen.sv
// Self-checking bench for fg_trapezoid_gen: vector table, hand-written corner
// sequences and randomized runs against a closed-form per-period model.
module tb_fg_trapezoid_gen;
    localparam int CW = 16;
    localparam int WW = 8;
    localparam int BW = 8;

    logic clk_i = 1'b0;
    logic rstn_i;

    fg_trapezoid_gen_if #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW), .BURST_BITWIDTH(BW)) bus ();

    fg_trapezoid_gen #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW), .BURST_BITWIDTH(BW)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit reset_first;
        int period;
        int on_time;
        int k_rise;
        int k_fall;
        int amp;
        bit invert;
        int exp_out;
        int exp_state;
        bit exp_busy;
        bit exp_ps;
    } vec_t;

    typedef struct {
        int out;
        bit busy;
        bit ps;
    } exp_t;

    vec_t vecs[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    int s1_out   [10] = '{0, 40, 80, 100, 100, 100, 50, 0, 0, 0};
    int s1_state [10] = '{1, 1, 1, 2, 2, 3, 3, 0, 0, 0};
    int s2_out   [6]  = '{0, 100, 100, 100, 0, 0};
    int s2_state [6]  = '{1, 2, 2, 3, 0, 0};
    int s3_out   [8]  = '{0, 50, 100, 100, 100, 50, 0, 0};

    function automatic void add_vec(bit rst, int p, int on, int kr, int kf, int amp, bit inv,
                                    int e_out, int e_state, bit e_busy, bit e_ps);
        vec_t v;
        v.reset_first = rst;
        v.period      = p;
        v.on_time     = on;
        v.k_rise      = kr;
        v.k_fall      = kf;
        v.amp         = amp;
        v.invert      = inv;
        v.exp_out     = e_out;
        v.exp_state   = e_state;
        v.exp_busy    = e_busy;
        v.exp_ps      = e_ps;
        vecs.push_back(v);
    endfunction

    function automatic int rise_val(int v0, int n, int kr, int amp);
        int s;
        if (kr == 0) return amp;
        s = v0 + n * kr;
        return (s >= amp) ? amp : s;
    endfunction

    // Closed-form sample at counter position n of a period that starts from value v0.
    function automatic int period_sample(int v0, int n, int p, int on, int kr, int kf, int amp);
        int d;
        if (n == 0) return v0;
        if (on >= 1 && on <= p - 1 && n > on) begin
            if (kf == 0) return 0;
            d = rise_val(v0, on, kr, amp) - (n - on) * kf;
            return (d < 0) ? 0 : d;
        end
        return rise_val(v0, n, kr, amp);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit en);
        bus.clk_en_i = en;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input int mode, input int p, input int on, input int kr, input int kf,
                           input int amp, input bit inv);
        bus.mode_i      = 2'(mode);
        bus.period_i    = CW'(p);
        bus.on_time_i   = CW'(on);
        bus.k_rise_i    = WW'(kr);
        bus.k_fall_i    = WW'(kf);
        bus.amplitude_i = WW'(amp);
        bus.invert_i    = inv;
    endtask

    task automatic do_reset();
        rstn_i       = 1'b0;
        bus.clk_en_i = 1'b0;
        bus.enable_i = 1'b0;
        bus.start_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 rstn_i = 1'b1;
    endtask

    task automatic run_random(input int idx);
        int   mode, p, on, kr, kf, amp, blen, n_per, v, v0, prev_out, exp_o;
        bit   inv, burst, falling;
        exp_t e;
        exp_t q[$];
        mode  = $urandom_range(0, 3);
        p     = $urandom_range(2, 12);
        on    = $urandom_range(0, 14);
        kr    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
        kf    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
        amp   = $urandom_range(0, 255);
        blen  = $urandom_range(0, 3);
        inv   = 1'($urandom_range(0, 1));
        burst = (mode == 1) || (mode == 2);
        do_reset();
        set_cfg(mode, p, on, kr, kf, amp, inv);
        bus.burst_len_i = BW'(blen);
        bus.enable_i    = 1'b1;

        v = 0;
        if (burst) begin
            e = '{0, 1'b1, 1'b0};
            q.push_back(e);
            n_per = (mode == 1) ? 1 : ((blen == 0) ? 1 : blen);
        end else begin
            n_per = 3;
        end
        for (int k = 0; k < n_per; k++) begin
            v0 = v;
            for (int n = 0; n < p; n++) begin
                v = period_sample(v0, n, p, on, kr, kf, amp);
                e = '{v, 1'b1, (n == 0)};
                q.push_back(e);
            end
        end
        if (burst) begin
            falling = (on >= 1 && on <= p - 1);
            if (!falling) begin
                e = '{v, 1'b1, 1'b0};
                q.push_back(e);
            end
            do begin
                v = (kf == 0 || v <= kf) ? 0 : v - kf;
                e = '{v, (v != 0), 1'b0};
                q.push_back(e);
            end while (v != 0);
            for (int k = 0; k < 3; k++) begin
                e = '{0, 1'b0, 1'b0};
                q.push_back(e);
            end
        end

        prev_out = 0;
        for (int i = 0; i < q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.start_i = 1'b0;
                applyStimulus(1'b0);
                checkOutput($sformatf("rnd%0d t%0d hold out", idx, i), int'(bus.out_o), prev_out);
                checkOutput($sformatf("rnd%0d t%0d hold ps", idx, i), int'(bus.period_start_o), 0);
            end
            if (burst && i == 0)           bus.start_i = 1'b1;
            else if (i > 0 && q[i-1].busy) bus.start_i = 1'($urandom_range(0, 1));
            else                           bus.start_i = 1'b0;
            applyStimulus(1'b1);
            exp_o = inv ? -q[i].out : q[i].out;
            checkOutput($sformatf("rnd%0d m%0d t%0d out", idx, mode, i), int'(bus.out_o), exp_o);
            checkOutput($sformatf("rnd%0d t%0d busy", idx, i), int'(bus.busy_o), int'(q[i].busy));
            checkOutput($sformatf("rnd%0d t%0d ps", idx, i), int'(bus.period_start_o), int'(q[i].ps));
            prev_out = exp_o;
        end
    endtask

    initial begin
        int peak1, peak2, off_count, ps_count, busy_bad;

        for (int i = 0; i < 20; i++) add_vec(i == 0, 10, 5, 40, 50, 100, 1'b0, s1_out[i%10], s1_state[i%10], 1'b1, (i % 10) == 0);
        for (int i = 0; i < 12; i++) add_vec(i == 0, 6, 3, 0, 0, 100, 1'b0, s2_out[i%6], s2_state[i%6], 1'b1, (i % 6) == 0);
        for (int i = 0; i < 10; i++) add_vec(i == 0, 10, 5, 40, 50, 100, 1'b1, -s1_out[i], s1_state[i], 1'b1, i == 0);
        for (int i = 0; i < 3; i++)  add_vec(i == 0, 1, 0, 40, 50, 100, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)  add_vec(i == 0, 0, 0, 40, 50, 100, 1'b0, 0, 0, 1'b0, 1'b0);

        set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
        bus.burst_len_i = '0;
        do_reset();
        #1;
        checkOutput("reset out", int'(bus.out_o), 0);
        checkOutput("reset busy", int'(bus.busy_o), 0);
        checkOutput("reset ps", int'(bus.period_start_o), 0);
        checkOutput("reset state", int'(bus.state_o), 0);

        foreach (vecs[i]) begin
            if (vecs[i].reset_first) do_reset();
            set_cfg(0, vecs[i].period, vecs[i].on_time, vecs[i].k_rise, vecs[i].k_fall,
                    vecs[i].amp, vecs[i].invert);
            bus.enable_i = 1'b1;
            applyStimulus(1'b1);
            checkOutput($sformatf("vec%0d out", i), int'(bus.out_o), vecs[i].exp_out);
            checkOutput($sformatf("vec%0d state", i), int'(bus.state_o), vecs[i].exp_state);
            checkOutput($sformatf("vec%0d busy", i), int'(bus.busy_o), int'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d ps", i), int'(bus.period_start_o), int'(vecs[i].exp_ps));
        end

        // Burst of two trapezoids with start pulses while busy.
        do_reset();
        set_cfg(2, 8, 4, 50, 50, 100, 1'b0);
        bus.burst_len_i = 8'd2;
        bus.enable_i    = 1'b1;
        ps_count = 0;
        busy_bad = 0;
        for (int t = 0; t < 18; t++) begin
            bus.start_i = (t == 0 || t == 3 || t == 10);
            applyStimulus(1'b1);
            ps_count += int'(bus.period_start_o);
            if (t >= 1 && t <= 16) checkOutput($sformatf("burst2 t%0d out", t), int'(bus.out_o), s3_out[(t-1)%8]);
            if (t <= 16 && !bus.busy_o) busy_bad++;
        end
        checkOutput("burst2 busy drop", int'(bus.busy_o), 0);
        checkOutput("burst2 end out", int'(bus.out_o), 0);
        checkOutput("burst2 busy gaps", busy_bad, 0);
        bus.start_i = 1'b0;
        repeat (3) begin
            applyStimulus(1'b1);
            ps_count += int'(bus.period_start_o);
        end
        checkOutput("burst2 idle busy", int'(bus.busy_o), 0);
        checkOutput("burst2 period count", ps_count, 2);

        // burst_len of zero behaves as a single period.
        bus.burst_len_i = 8'd0;
        ps_count = 0;
        for (int t = 0; t < 10; t++) begin
            bus.start_i = (t == 0);
            applyStimulus(1'b1);
            ps_count += int'(bus.period_start_o);
            if (t == 8) checkOutput("burst0 busy last", int'(bus.busy_o), 1);
        end
        checkOutput("burst0 busy drop", int'(bus.busy_o), 0);
        checkOutput("burst0 period count", ps_count, 1);

        // Mid-period amplitude change, then enable dropped during RISE.
        do_reset();
        set_cfg(0, 10, 5, 40, 50, 100, 1'b0);
        bus.enable_i = 1'b1;
        peak1 = 0;
        peak2 = 0;
        for (int t = 0; t < 20; t++) begin
            if (t == 2) bus.amplitude_i = 8'd60;
            applyStimulus(1'b1);
            if (t < 10 && int'(bus.out_o) > peak1) peak1 = int'(bus.out_o);
            if (t >= 10 && int'(bus.out_o) > peak2) peak2 = int'(bus.out_o);
        end
        checkOutput("amp change peak old", peak1, 100);
        checkOutput("amp change peak new", peak2, 60);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("pre-stop state", int'(bus.state_o), 1);
        bus.enable_i = 1'b0;
        applyStimulus(1'b1);
        checkOutput("stop out", int'(bus.out_o), 0);
        checkOutput("stop state", int'(bus.state_o), 0);
        checkOutput("stop busy", int'(bus.busy_o), 0);

        // on_time beyond the period: saturates at amplitude.
        do_reset();
        set_cfg(0, 10, 12, 40, 50, 100, 1'b0);
        bus.enable_i = 1'b1;
        off_count = 0;
        for (int t = 0; t < 30; t++) begin
            applyStimulus(1'b1);
            if (t >= 3 && int'(bus.out_o) != 100) off_count++;
        end
        checkOutput("saturate off ticks", off_count, 0);
        checkOutput("saturate out", int'(bus.out_o), 100);
        checkOutput("saturate state", int'(bus.state_o), 2);

        // Asynchronous reset in the middle of FALL, then a clean restart.
        do_reset();
        set_cfg(0, 10, 5, 40, 50, 100, 1'b0);
        bus.enable_i = 1'b1;
        for (int t = 0; t < 7; t++) applyStimulus(1'b1);
        checkOutput("pre-reset state", int'(bus.state_o), 3);
        checkOutput("pre-reset out", int'(bus.out_o), 50);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("async reset out", int'(bus.out_o), 0);
        checkOutput("async reset state", int'(bus.state_o), 0);
        checkOutput("async reset busy", int'(bus.busy_o), 0);
        @(posedge clk_i);
        #2 rstn_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("restart t%0d out", t), int'(bus.out_o), s1_out[t]);
        end

        for (int r = 0; r < 40; r++) run_random(r);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fg_trapezoid_gen.md
Name: fg_trapezoid_gen

Overview:
Single-channel trapezoid/pulse generator with its own period counter. Slope and timing settings are held in shadow registers. Supports continuous, one-shot and burst modes, plus output inversion. It sits between the function-generator register file and the output formatter/DAC path. Its output is a signed sample that updates once per clk_en_i tick.

Parameters:
COUNTER_BITWIDTH, 16, width of the period and on-time counters
WAVEFORM_BITWIDTH, 12, width of the unsigned amplitude and slope values
BURST_BITWIDTH, 8, width of the burst period count

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
clk_en_i  in  1  sample tick; all state advances only when high
enable_i  in  1  run enable; low means synchronous stop
start_i  in  1  trigger for one-shot/burst; ignored while busy_o is high
mode_i  in  2  0 continuous, 1 one-shot, 2 burst, 3 treated as continuous
burst_len_i  in  BURST_BITWIDTH  periods per burst; 0 is treated as 1
period_i  in  COUNTER_BITWIDTH  period length P in ticks
on_time_i  in  COUNTER_BITWIDTH  counter value at which the fall starts
k_rise_i  in  WAVEFORM_BITWIDTH  rise step per tick (unsigned); 0 means instantaneous step
k_fall_i  in  WAVEFORM_BITWIDTH  fall step per tick (unsigned); 0 means instantaneous step
amplitude_i  in  WAVEFORM_BITWIDTH  peak value (unsigned)
invert_i  in  1  1 selects out_o = -val
out_o  out  WAVEFORM_BITWIDTH+1  signed sample, registered
busy_o  out  1  generator is running or draining
period_start_o  out  1  one-clock pulse in the cycle after each cnt==0 tick
state_o  out  2  0 IDLE, 1 RISE, 2 ON, 3 FALL

Behaviour:
- Reset (async, rstn_i low): cnt=0, state IDLE, val=0, shadows=0, burst counter=0, out_o=0, busy_o=0, period_start_o=0.
- clk_en_i low: everything holds; period_start_o=0.
- Run condition:
  - Continuous: runs while enable_i is high.
  - One-shot/burst: a start tick (start_i high with busy_o low) sets busy_o and latches the period count (1 for one-shot, max(burst_len_i,1) for burst).
- cnt counts 0..P-1 on ticks, then wraps to 0. If P<2, the block holds IDLE, val=0, busy_o=0.
- Tick with cnt==0:
  - Load shadows: period, on_time, k_rise, k_fall, amplitude.
  - state<=RISE; val is unchanged, so a restart continues from the current val without a glitch.
  - Pulse period_start_o in the next cycle.
  - Register inputs are sampled only here; mid-period changes have no effect until the next period.
- Per tick, by state (all from pre-edge values):
  - IDLE: val<=0.
  - RISE:
    - If cnt==on_time: state<=FALL; val follows the RISE rule for this tick.
    - Else if val+k_rise>=amp or k_rise==0: val<=amp, state<=ON.
    - Else: val<=val+k_rise.
  - ON: val<=amp; if cnt==on_time, state<=FALL.
  - FALL: if val<=k_fall or k_fall==0, val<=0 and state<=IDLE; else val<=val-k_fall.
- Priority: a cnt==0 restart overrides every transition above.
- on_time>=P: the fall never starts; the waveform saturates at amp.
- Arithmetic: sums use WAVEFORM_BITWIDTH+1 bits unsigned, so there is no overflow; val stays in [0,amp].
- out_o = invert_i ? -val : val (two's complement), registered and applied on the same tick as the val update.
- End of the last one-shot/burst period (cnt wraps to 0):
  - No restart; the burst counter is exhausted.
  - RISE/ON go directly to FALL; the block drains to val=0.
  - busy_o falls in the tick where the state reaches IDLE.
- enable_i low on a tick: cnt<=0, state IDLE, val<=0, busy_o<=0 on the next edge, even mid-burst.
- Async reset mid-operation: immediate return to the reset values; no partial shadow load.

Test Plan:
1. WB=8, continuous, P=10, on=5, k_rise=40, k_fall=50, amp=100 -> out_o after ticks cnt0..9 = 0,40,80,100,100,100,50,0,0,0, repeating every 10 ticks; period_start_o pulses once per 10 ticks.
2. k_rise=0, k_fall=0, amp=100, P=6, on=3 -> 0,100,100,100,0,0; state_o sequence 1,2,2,3,0,0.
3. Burst mode, burst_len=2, P=8, on=4, k_rise=k_fall=50, amp=100 -> exactly two trapezoids; busy_o high from the start tick until val returns to 0; start_i pulses during busy are ignored; burst_len=0 gives one period.
4. invert_i=1 with scenario 1 -> peak out_o = 9'h19C (-100), idle 0.
5. amplitude_i changed 100->60 at cnt=2 -> current period peaks at 100; next period peaks at 60. enable_i dropped in RISE -> next edge out_o=0, state_o=0, busy_o=0.
6. on_time=12 > P=10 with k_rise=40, amp=100 -> out_o settles at 100, never falls. Async rstn_i pulse mid-FALL -> out_o=0 immediately; the restart matches scenario 1.
